// File: rtl/flappy_pkg.sv
// Shared types for the Flappy game sequencer: state encodings (LED order),
// two-digit BCD score type, signed bird velocity type and BCD increment helper.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef logic [7:0] bcd2_t;

  localparam int VEL_W = 6;
  typedef logic signed [VEL_W-1:0] vel_t;

  // Ones digit wraps into tens; 99 holds.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_bcd_counter2.sv
// Two-digit BCD counter with increment, synchronous clear and saturation at 99.
module bcd_counter2
  import flappy_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr_i,
  input  logic  inc_i,
  output bcd2_t count_o
);

  bcd2_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = 8'h00;
    else if (inc_i)
      count_d = bcd_inc(count_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= 8'h00;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy game sequencer: state machine, per-frame bird physics, BCD scoring.
// Optional macro HISCORE_EN enables the persistent best-score register.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int         Y_INIT    = 240,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 470,
  parameter int         FLAP_VEL  = 6,
  parameter int         GRAVITY   = 1,
  parameter int         VMAX      = 8,
  parameter logic [7:0] WIN_SCORE = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       flap,
  input  logic       frame_tick,
  input  logic       collide,
  input  logic       pipe_passed,
  output logic [1:0] state,
  output logic [9:0] bird_y,
  output logic       scroll_en,
  output logic [7:0] score,
  output logic       win,
  output logic [7:0] hiscore
);

  localparam logic signed [VEL_W:0] GRAV_S = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0] VMAX_S = (VEL_W+1)'(VMAX);
  localparam vel_t                  FLAP_V = VEL_W'(-FLAP_VEL);
  localparam logic signed [10:0]    Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0]    Y_MAX_S = 11'(Y_MAX);

  state_t                  state_q, state_d;
  logic [9:0]              bird_y_q, bird_y_d;
  vel_t                    vel_q, vel_d;
  logic                    win_q, win_d;
  logic                    scroll_q;
  logic                    flap_prev_q;
  logic                    flap_pend_q, flap_pend_d;
  logic                    score_clr, score_inc;
  bcd2_t                   score_q;

  logic                    flap_edge;
  logic signed [VEL_W:0]   vel_sum;
  vel_t                    vel_grav, new_vel, vel_phys;
  logic signed [10:0]      y_sum;
  logic                    hit_top, crash;
  logic [9:0]              y_phys;

  assign flap_edge = flap & ~flap_prev_q;

  // Shared physics step; only PLAY honours a pending flap.
  always_comb begin
    vel_sum  = signed'({vel_q[VEL_W-1], vel_q}) + GRAV_S;
    vel_grav = (vel_sum > VMAX_S) ? VEL_W'(VMAX_S) : VEL_W'(vel_sum);
    new_vel  = (state_q == ST_PLAY && flap_pend_q) ? FLAP_V : vel_grav;
    y_sum    = signed'({1'b0, bird_y_q}) + 11'(new_vel);
    hit_top  = (y_sum < Y_MIN_S);
    crash    = (y_sum >= Y_MAX_S);
    y_phys   = hit_top ? 10'(Y_MIN) : (crash ? 10'(Y_MAX) : y_sum[9:0]);
    vel_phys = hit_top ? vel_t'(0) : new_vel;
  end

  always_comb begin
    state_d     = state_q;
    bird_y_d    = bird_y_q;
    vel_d       = vel_q;
    win_d       = win_q;
    flap_pend_d = flap_pend_q;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bird_y_d    = 10'(Y_INIT);
        vel_d       = '0;
        flap_pend_d = 1'b0;
        if (frame_tick && start) begin
          state_d   = ST_PLAY;
          score_clr = 1'b1;
          win_d     = 1'b0;
        end
      end
      ST_PLAY: begin
        flap_pend_d = flap_pend_q | flap_edge;
        if (frame_tick) begin
          // An edge arriving with the tick waits for the following tick.
          flap_pend_d = flap_edge;
          bird_y_d    = y_phys;
          vel_d       = vel_phys;
          if (crash) begin
            state_d = ST_DONE;
            win_d   = 1'b0;
          end else if (!hit_top && collide) begin
            state_d = ST_DYING;
          end
        end
        // Reaching the win score overrides a same-tick collision, not a crash.
        if (pipe_passed && !(frame_tick && crash)) begin
          if (bcd_inc(score_q) == WIN_SCORE) begin
            score_inc = 1'b1;
            state_d   = ST_DONE;
            win_d     = 1'b1;
          end else if (state_d == ST_PLAY) begin
            score_inc = 1'b1;
          end
        end
        if (state_d != ST_PLAY)
          flap_pend_d = 1'b0;
      end
      ST_DYING: begin
        flap_pend_d = 1'b0;
        if (frame_tick) begin
          bird_y_d = y_phys;
          vel_d    = vel_phys;
          if (crash) begin
            state_d = ST_DONE;
            win_d   = 1'b0;
          end
        end
      end
      ST_DONE: begin
        flap_pend_d = 1'b0;
        if (!start) begin
          state_d  = ST_IDLE;
          bird_y_d = 10'(Y_INIT);
          vel_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bird_y_q    <= 10'(Y_INIT);
      vel_q       <= '0;
      win_q       <= 1'b0;
      scroll_q    <= 1'b0;
      flap_prev_q <= 1'b0;
      flap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bird_y_q    <= bird_y_d;
      vel_q       <= vel_d;
      win_q       <= win_d;
      scroll_q    <= (state_d == ST_PLAY);
      flap_prev_q <= flap;
      flap_pend_q <= flap_pend_d;
    end
  end

  bcd_counter2 u_score (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .count_o (score_q)
  );

`ifdef HISCORE_EN
  bcd2_t hiscore_q, score_nx;

  // Valid BCD orders the same as plain binary, so a direct compare suffices.
  always_comb begin
    score_nx = score_q;
    if (score_clr)
      score_nx = 8'h00;
    else if (score_inc)
      score_nx = bcd_inc(score_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hiscore_q <= 8'h00;
    else if (state_d == ST_DONE && state_q != ST_DONE && score_nx > hiscore_q)
      hiscore_q <= score_nx;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 8'h00;
`endif

  assign state     = state_q;
  assign bird_y    = bird_y_q;
  assign scroll_en = scroll_q;
  assign score     = score_q;
  assign win       = win_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: physics, flap timing, scoring, win/lose, hiscore.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       flap = 1'b0;
  logic       frame_tick = 1'b0;
  logic       collide = 1'b0;
  logic       pipe_passed = 1'b0;
  logic [1:0] state;
  logic [9:0] bird_y;
  logic       scroll_en;
  logic [7:0] score;
  logic       win;
  logic [7:0] hiscore;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef HISCORE_EN
  localparam logic [7:0] EXP_HI = 8'h05;
`else
  localparam logic [7:0] EXP_HI = 8'h00;
`endif

  always #5 clk = ~clk;

  flappy_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .flap        (flap),
    .frame_tick  (frame_tick),
    .collide     (collide),
    .pipe_passed (pipe_passed),
    .state       (state),
    .bird_y      (bird_y),
    .scroll_en   (scroll_en),
    .score       (score),
    .win         (win),
    .hiscore     (hiscore)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic flap_pulse();
    flap = 1'b1;
    step();
    flap = 1'b0;
    step();
  endtask

  task automatic pipe_pulse();
    pipe_passed = 1'b1;
    step();
    pipe_passed = 1'b0;
  endtask

  task automatic fall_to_done(input string tag);
    int n = 0;
    while (state != 2'b11 && n < 200) begin
      tick();
      step();
      n++;
    end
    check({tag, "_state"}, 32'(state), 32'h3);
    check({tag, "_y"}, 32'(bird_y), 32'd470);
    check({tag, "_scroll"}, 32'(scroll_en), 32'h0);
  endtask

  initial begin
    step();
    step();
    check("rst_state", 32'(state), 32'h0);
    check("rst_y", 32'(bird_y), 32'd240);
    check("rst_score", 32'(score), 32'h0);
    check("rst_scroll", 32'(scroll_en), 32'h0);
    check("rst_win", 32'(win), 32'h0);
    check("rst_hi", 32'(hiscore), 32'h0);
    reset = 1'b0;
    step();

    // Game 1: start, free fall, single flap, ground crash.
    start = 1'b1;
    tick();
    check("start_state", 32'(state), 32'h1);
    check("start_scroll", 32'(scroll_en), 32'h1);
    tick(); check("fall1_y", 32'(bird_y), 32'd241);
    tick(); check("fall2_y", 32'(bird_y), 32'd243);
    tick(); check("fall3_y", 32'(bird_y), 32'd246);
    flap_pulse();
    tick();
    check("flap_y", 32'(bird_y), 32'd240);
    check("flap_state", 32'(state), 32'h1);
    fall_to_done("ground");
    check("ground_win", 32'(win), 32'h0);
    start = 1'b0;
    step();
    check("idle_state", 32'(state), 32'h0);
    check("idle_y", 32'(bird_y), 32'd240);

    // Game 2: double flap, flap coinciding with tick, collision with pipe.
    start = 1'b1;
    tick();
    check("g2_state", 32'(state), 32'h1);
    flap_pulse();
    flap_pulse();
    tick();
    check("dblflap_y", 32'(bird_y), 32'd234);
    flap = 1'b1;
    frame_tick = 1'b1;
    step();
    flap = 1'b0;
    frame_tick = 1'b0;
    check("flaptick_y", 32'(bird_y), 32'd229);
    step();
    tick();
    check("flaplate_y", 32'(bird_y), 32'd223);
    collide = 1'b1;
    pipe_passed = 1'b1;
    tick();
    collide = 1'b0;
    pipe_passed = 1'b0;
    check("coll_state", 32'(state), 32'h2);
    check("coll_y", 32'(bird_y), 32'd218);
    check("coll_score", 32'(score), 32'h0);
    check("coll_scroll", 32'(scroll_en), 32'h0);
    fall_to_done("dying");
    check("dying_score", 32'(score), 32'h0);
    start = 1'b0;
    step();

    // Game 3: ten pipes reach the win score.
    start = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      pipe_pulse();
      check("win_score", 32'(score), (i == 10) ? 32'h10 : 32'(i));
      check("win_state", 32'(state), (i == 10) ? 32'h3 : 32'h1);
    end
    check("win_flag", 32'(win), 32'h1);
    check("win_scroll", 32'(scroll_en), 32'h0);
    start = 1'b0;
    step();
    check("win_idle_state", 32'(state), 32'h0);
    check("win_idle_score", 32'(score), 32'h10);

    // Hiscore: 05 then 03 keeps 05; async reset clears it.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) pipe_pulse();
    collide = 1'b1;
    tick();
    collide = 1'b0;
    fall_to_done("hs1");
    check("hs1_score", 32'(score), 32'h05);
    check("hs1_hi", 32'(hiscore), 32'(EXP_HI));
    start = 1'b0;
    step();
    start = 1'b1;
    tick();
    check("hs2_clr", 32'(score), 32'h0);
    for (int i = 0; i < 3; i++) pipe_pulse();
    collide = 1'b1;
    tick();
    collide = 1'b0;
    fall_to_done("hs2");
    check("hs2_score", 32'(score), 32'h03);
    check("hs2_hi", 32'(hiscore), 32'(EXP_HI));
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'h0);
    check("arst_y", 32'(bird_y), 32'd240);
    check("arst_score", 32'(score), 32'h0);
    check("arst_hi", 32'(hiscore), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game sequencer for the Flappy VGA design: owns the top-level game state machine, per-frame bird physics (gravity, flap impulse, ground/ceiling clamp), BCD scoring and win/lose detection. Sits between the input buffers (start switch, flap button) and the renderer/hvsync generator. It consumes a once-per-frame tick and a collision flag from the renderer, and drives bird position, scroll enable, score digits and state to the VGA, LED and SSD logic.

## Interface
Parameters:
- Y_INIT, 240: bird row at reset and in IDLE.
- Y_MIN, 0: top clamp row.
- Y_MAX, 470: ground row; reaching it is a crash.
- FLAP_VEL, 6: upward speed, rows/frame, loaded on flap.
- GRAVITY, 1: velocity increment per frame.
- VMAX, 8: terminal downward velocity.
- WIN_SCORE, 8'h10: BCD score that ends the game as a win.

Ports:
- clk  in  1  system clock (same domain as the hvsync generator).
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level: run request (switch).
- flap  in  1  level: flap button, already debounced.
- frame_tick  in  1  one-cycle pulse per frame (vsync start).
- collide  in  1  level from renderer: bird overlaps a pipe.
- pipe_passed  in  1  one-cycle pulse: bird cleared a pipe.
- state  out  2  00 IDLE, 01 PLAY, 10 DYING, 11 DONE.
- bird_y  out  10  bird centre row.
- scroll_en  out  1  pipes scroll; high only in PLAY.
- score  out  8  two BCD digits {tens, ones}.
- win  out  1  DONE reached via WIN_SCORE.
- hiscore  out  8  BCD best score (see Configuration).

## Operation
- All outputs registered. Reset values: state=IDLE, bird_y=Y_INIT, velocity=0, score=0, scroll_en=0, win=0, hiscore=0.
- Velocity: internal signed 6-bit, negative = upward.
- Flap edge detect: rising edge of flap (registered copy) sets flap_pend. Cleared on consumption, or when leaving PLAY. Multiple edges within one frame collapse to one.
- IDLE: bird_y held at Y_INIT, velocity 0. On a frame_tick with start=1, go to PLAY and clear score and win.
- PLAY, on frame_tick:
  - New velocity: -FLAP_VEL if flap_pend, else min(vel+GRAVITY, VMAX).
  - bird_y <= bird_y + new velocity, computed at 11 bits signed, then clamped.
  - Result < Y_MIN: bird_y=Y_MIN, velocity=0.
  - Result >= Y_MAX: bird_y=Y_MAX, next state DONE (ground crash, win=0).
  - Otherwise, if collide=1: next state DYING.
- Scoring: pipe_passed in any PLAY cycle increments score (BCD, ones 9 wraps to 0 and carries into tens, saturates at 99).
  - Exception: pipe_passed coinciding with a frame_tick that transitions to DYING or DONE is ignored.
  - When score becomes WIN_SCORE: state DONE, win=1 on the next cycle. This takes priority over a collide on the same tick.
- DYING: flaps ignored, scroll_en=0. Each frame_tick applies gravity only. Reaching Y_MAX goes to DONE.
- DONE: bird_y, score and win frozen. When start=0 go to IDLE; score stays displayed until the next game starts.
- start dropping in PLAY or DYING has no effect; only reset aborts a game.
- Reset mid-game returns every output to its reset value asynchronously.

## Timing
- Physics, score and state update on the clock edge after the frame_tick or pipe_passed cycle (1-cycle latency).
- Flap latency: an edge at cycle n is applied at the first frame_tick at or after cycle n+1.
- scroll_en changes in the same cycle as state.
- A frame_tick and a flap edge in the same cycle: that edge is applied at the next frame_tick.

## Configuration
- HISCORE_EN defined:
  - hiscore register active.
  - On entry to DONE, hiscore <= score if score > hiscore (BCD compare).
  - Persists across games; cleared only by reset.
- HISCORE_EN undefined: hiscore tied to 8'h00, no register inferred.

## Structure
- Package flappy_pkg holds:
  - state encodings (IDLE/PLAY/DYING/DONE), matching the LED mapping;
  - the 8-bit BCD score typedef;
  - the signed velocity typedef and its width.
- One sub-module: bcd_counter2. Two-digit BCD with increment, synchronous clear and saturate-at-99; used for score.

## Test plan
- Reset, start=1, frame_tick: state=01 one cycle after tick. Three more ticks, no flap: bird_y 241, 243, 246.
- Flap pulse then tick from bird_y=246, vel=3: vel=-6, bird_y=240. Two flap edges in one frame give the same result.
- No flaps until ground: bird_y clamps at 470, state=11, win=0, scroll_en=0.
- collide=1 on a tick, together with a simultaneous pipe_passed: state=10, score unchanged. Then falls to 470 → state=11.
- Ten pipe_passed pulses: score steps 01..09 to 8'h10, state=11, win=1. Drop start: state=00, score still 8'h10.
- With HISCORE_EN: game 1 scores 05, game 2 scores 03 → hiscore=05. Reset → hiscore=00.
